// File: rtl/rf_read.sv
// rtl/rf_read.sv - operand-read side of the register file with busy scoreboard; optional forwarding under RF_BYPASS_EN
module rf_read #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_W*(1<<ADDR_W)-1:0]      out_rf,
  input  logic                               ld_rf,
  input  logic [ADDR_W-1:0]                  dest,
  input  logic [DATA_W-1:0]                  from_alu,
  input  logic                               busy_set,
  input  logic [ADDR_W-1:0]                  busy_dest,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [ADDR_W-1:0]                  src_a,
  input  logic [ADDR_W-1:0]                  src_b,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [DATA_W-1:0]                  opnd_a,
  output logic [DATA_W-1:0]                  opnd_b,
  output logic [(1<<ADDR_W)-1:0]             busy
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FULL} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   lat_a, lat_b;
  logic [ADDR_W-1:0]   sel_a, sel_b;
  logic                hit_a, hit_b;
  logic                rdy_a, rdy_b, both_rdy;
  logic [DATA_W-1:0]   val_a, val_b;
  logic                accept, load;
  logic [NREG-1:0]     busy_nxt;

  // Pick the sources under evaluation: held ones while waiting, live request otherwise
  always_comb begin
    sel_a = (state == ST_WAIT) ? lat_a : src_a;
    sel_b = (state == ST_WAIT) ? lat_b : src_b;
    hit_a = ld_rf && (dest == sel_a);
    hit_b = ld_rf && (dest == sel_b);
  end

`ifdef RF_BYPASS_EN
  // A same-cycle write-back satisfies the read and supplies the value directly
  always_comb begin
    rdy_a = !busy[sel_a] || hit_a;
    rdy_b = !busy[sel_b] || hit_b;
    val_a = hit_a ? from_alu : out_rf[DATA_W*sel_a +: DATA_W];
    val_b = hit_b ? from_alu : out_rf[DATA_W*sel_b +: DATA_W];
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^from_alu;

  // A register being written this cycle is not readable until the file has updated
  always_comb begin
    rdy_a = !busy[sel_a] && !hit_a;
    rdy_b = !busy[sel_b] && !hit_b;
    val_a = out_rf[DATA_W*sel_a +: DATA_W];
    val_b = out_rf[DATA_W*sel_b +: DATA_W];
  end
`endif

  assign both_rdy = rdy_a && rdy_b;
  assign accept   = req_valid && req_ready;
  assign load     = (state == ST_WAIT) ? both_rdy : (accept && both_rdy);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accepted requests go to FULL when ready, else park in WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = both_rdy ? ST_FULL : ST_WAIT;
      end
      ST_WAIT: begin
        if (both_rdy) state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (rd_ready) begin
          if (accept) state_nxt = both_rdy ? ST_FULL : ST_WAIT;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs: a held result frees the slot only when the consumer takes it
  always_comb begin
    req_ready = (state == ST_IDLE) || ((state == ST_FULL) && rd_ready);
    rd_valid  = (state == ST_FULL);
  end

  // Capture request sources on accept and operands once both are available
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_a  <= '0;
      lat_b  <= '0;
      opnd_a <= '0;
      opnd_b <= '0;
    end else begin
      if (accept) begin
        lat_a <= src_a;
        lat_b <= src_b;
      end
      if (load) begin
        opnd_a <= val_a;
        opnd_b <= val_b;
      end
    end
  end

  // Scoreboard update: clear on write-back, then set on issue so set wins
  always_comb begin
    busy_nxt = busy;
    if (ld_rf)    busy_nxt[dest]      = 1'b0;
    if (busy_set) busy_nxt[busy_dest] = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: tb/tb_rf_read.sv
// tb/tb_rf_read.sv - randomized and directed checks of rf_read against a transaction model
module tb_rf_read;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] out_rf;
  logic         ld_rf, busy_set, req_valid, rd_ready;
  logic [2:0]   dest, busy_dest, src_a, src_b;
  logic [15:0]  from_alu;
  logic         req_ready, rd_valid;
  logic [15:0]  opnd_a, opnd_b;
  logic [7:0]   busy;

  int checks = 0;
  int errors = 0;

  // environment register file and reference model state
  logic [15:0] mem [8];
  bit          m_busy [8];
  bit          m_full, m_pend;
  int          m_sa, m_sb;
  logic [15:0] m_a, m_b;

  always #5 clk = ~clk;

  always_comb for (int r = 0; r < 8; r++) out_rf[16*r +: 16] = mem[r];

  rf_read dut (
    .clk(clk), .rst(rst), .out_rf(out_rf), .ld_rf(ld_rf), .dest(dest),
    .from_alu(from_alu), .busy_set(busy_set), .busy_dest(busy_dest),
    .req_valid(req_valid), .req_ready(req_ready), .src_a(src_a), .src_b(src_b),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit src_ok(int s);
    bit hit = ld_rf && (int'(dest) == s);
`ifdef RF_BYPASS_EN
    return !m_busy[s] || hit;
`else
    return !m_busy[s] && !hit;
`endif
  endfunction

  function automatic logic [15:0] src_val(int s);
`ifdef RF_BYPASS_EN
    if (ld_rf && int'(dest) == s) return from_alu;
`endif
    return mem[s];
  endfunction

  function automatic logic [7:0] model_busy();
    logic [7:0] v;
    for (int r = 0; r < 8; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_busy[r] = 0;
    m_full = 0; m_pend = 0; m_sa = 0; m_sb = 0; m_a = '0; m_b = '0;
  endtask

  task automatic idle_inputs();
    ld_rf = 0; dest = 0; from_alu = 0; busy_set = 0; busy_dest = 0;
    req_valid = 0; src_a = 0; src_b = 0; rd_ready = 1;
  endtask

  // one clock: compare DUT against model, then advance model and register file
  task automatic tick();
    bit n_full, n_pend, mready, acc;
    int n_sa, n_sb;
    logic [15:0] n_a, n_b;
    bit n_busy [8];
    @(negedge clk);
    mready = !m_pend && (!m_full || rd_ready);
    check_eq("rd_valid", rd_valid, m_full);
    check_eq("req_ready", req_ready, mready);
    check_eq("busy", busy, model_busy());
    if (m_full) begin
      check_eq("opnd_a", opnd_a, m_a);
      check_eq("opnd_b", opnd_b, m_b);
    end
    n_full = m_full; n_pend = m_pend; n_sa = m_sa; n_sb = m_sb; n_a = m_a; n_b = m_b;
    acc = req_valid && mready;
    if (m_pend) begin
      if (src_ok(m_sa) && src_ok(m_sb)) begin
        n_pend = 0; n_full = 1; n_a = src_val(m_sa); n_b = src_val(m_sb);
      end
    end else begin
      if (m_full && rd_ready) n_full = 0;
      if (acc) begin
        if (src_ok(src_a) && src_ok(src_b)) begin
          n_full = 1; n_a = src_val(src_a); n_b = src_val(src_b);
        end else begin
          n_pend = 1; n_sa = src_a; n_sb = src_b;
        end
      end
    end
    for (int r = 0; r < 8; r++) n_busy[r] = m_busy[r];
    if (ld_rf) n_busy[dest] = 0;
    if (busy_set) n_busy[busy_dest] = 1;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      m_full = n_full; m_pend = n_pend; m_sa = n_sa; m_sb = n_sb; m_a = n_a; m_b = n_b;
      for (int r = 0; r < 8; r++) m_busy[r] = n_busy[r];
      if (ld_rf) mem[dest] = from_alu;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!rd_valid && n < 8) begin tick(); n++; end
    check_eq(tag, rd_valid, 1'b1);
  endtask

  initial begin
    for (int r = 0; r < 8; r++) mem[r] = 16'(r * 16'h0101);
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();

    // reset state
    @(negedge clk);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_busy", busy, 8'h00);
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_opnd_a", opnd_a, 16'h0000);
    @(posedge clk); #1;

    // basic read
    mem[2] = 16'h1234; mem[5] = 16'hBEEF;
    req_valid = 1; src_a = 2; src_b = 5;
    tick();
    req_valid = 0;
    check_eq("basic_valid", rd_valid, 1'b1);
    check_eq("basic_a", opnd_a, 16'h1234);
    check_eq("basic_b", opnd_b, 16'hBEEF);
    check_eq("basic_busy", busy, 8'h00);
    tick();

    // stall on pending register 3, released by write-back
    busy_set = 1; busy_dest = 3;
    tick();
    busy_set = 0;
    req_valid = 1; src_a = 3; src_b = 0;
    tick();
    req_valid = 0;
    check_eq("wait_req_ready", req_ready, 1'b0);
    check_eq("wait_rd_valid", rd_valid, 1'b0);
    tick(); tick();
    ld_rf = 1; dest = 3; from_alu = 16'h00AA;
    tick();
    ld_rf = 0;
`ifdef RF_BYPASS_EN
    check_eq("byp_valid", rd_valid, 1'b1);
`else
    check_eq("nobyp_bubble", rd_valid, 1'b0);
`endif
    wait_valid("wb_timeout");
    check_eq("wb_opnd_a", opnd_a, 16'h00AA);
    check_eq("wb_busy3", busy[3], 1'b0);
    tick();

    // back-to-back requests
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; src_a = 3'(2*i + 1); src_b = 3'(2*i + 2);
      tick();
      check_eq("b2b_valid", rd_valid, 1'b1);
      check_eq("b2b_ready", req_ready, 1'b1);
      check_eq("b2b_a", opnd_a, mem[2*i + 1]);
    end
    req_valid = 0;
    tick();

    // consumer stall holds operands
    req_valid = 1; src_a = 2; src_b = 5;
    tick();
    rd_ready = 0; src_a = 6; src_b = 7;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_valid", rd_valid, 1'b1);
      check_eq("hold_a", opnd_a, 16'h1234);
      check_eq("hold_ready", req_ready, 1'b0);
    end
    rd_ready = 1;
    #1 check_eq("release_ready", req_ready, 1'b1);
    tick();
    req_valid = 0;
    check_eq("release_a", opnd_a, mem[6]);
    tick();

    // scoreboard set/clear collisions
    busy_set = 1; busy_dest = 7;
    tick();
    busy_dest = 4;
    tick();
    busy_dest = 7; ld_rf = 1; dest = 7; from_alu = 16'h7777;
    tick();
    check_eq("setwins7", busy[7], 1'b1);
    busy_dest = 1; dest = 4; from_alu = 16'h4444;
    tick();
    busy_set = 0; ld_rf = 0;
    check_eq("set1", busy[1], 1'b1);
    check_eq("clr4", busy[4], 1'b0);

    // reset while waiting drops the request
    req_valid = 1; src_a = 1; src_b = 1;
    tick();
    req_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    check_eq("wrst_valid", rd_valid, 1'b0);
    check_eq("wrst_busy", busy, 8'h00);
    check_eq("wrst_ready", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      ld_rf     = !rst && ($urandom_range(0, 2) == 0);
      dest      = 3'($urandom);
      from_alu  = 16'($urandom);
      busy_set  = ($urandom_range(0, 4) == 0);
      busy_dest = 3'($urandom);
      req_valid = ($urandom_range(0, 9) < 6);
      src_a     = 3'($urandom);
      src_b     = ($urandom_range(0, 7) == 0) ? src_a : 3'($urandom);
      rd_ready  = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 0;
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
